// File: rtl/ex_mul_ctrl.sv
// EX-stage multiply issue/retire controller: latches operands, holds the
// iterative multiplier running, stalls the pipe and retires via valid/ready.
module ex_mul_ctrl #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mul_req_i,
  input  logic [2:0]  ex_mul_op_i,
  input  logic [31:0] ex_rs1_i,
  input  logic [31:0] ex_rs2_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic        flush_i,
  output logic        mul_start_o,
  output logic [31:0] mul_multiplicand_o,
  output logic [31:0] mul_multiplier_o,
  output logic [2:0]  mul_op_o,
  output logic [4:0]  mul_reg_waddr_o,
  input  logic        mul_ready_i,
  input  logic [31:0] mul_res_i,
  output logic        stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o,
  input  logic        wb_ready_i,
  output logic        mul_err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rs1_q, rs2_q, res_q;
  logic [2:0]    op_q;
  logic [4:0]    waddr_q;
  logic          accept, timeout;

  // x0 destinations are retired as no-ops without ever touching the multiplier
  assign accept  = (state_q == IDLE) & ex_mul_req_i & ~flush_i & (ex_waddr_i != 5'd0);
  // a product arriving in the last allowed cycle still wins over the watchdog
  assign timeout = (state_q == RUN) & (cnt_q == TO_CNT) & ~mul_ready_i & ~flush_i;

  always_comb begin
    state_d     = state_q;
    mul_start_o = 1'b0;
    stall_o     = 1'b0;
    wb_valid_o  = 1'b0;
    mul_err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = accept;
        if (accept) state_d = RUN;
      end
      RUN: begin
        stall_o     = 1'b1;
        mul_start_o = ~flush_i & ~timeout;
        mul_err_o   = timeout;
        if (flush_i)          state_d = IDLE;
        else if (mul_ready_i) state_d = DONE;
        else if (timeout)     state_d = IDLE;
      end
      DONE: begin
        wb_valid_o = 1'b1;
        stall_o    = ~(wb_ready_i & ~flush_i);
        if (flush_i | wb_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op_q    <= '0;
      waddr_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rs1_q   <= ex_rs1_i;
        rs2_q   <= ex_rs2_i;
        op_q    <= ex_mul_op_i;
        waddr_q <= ex_waddr_i;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == RUN) && mul_ready_i && !flush_i) res_q <= mul_res_i;
    end
  end

  assign mul_multiplicand_o = rs1_q;
  assign mul_multiplier_o   = rs2_q;
  assign mul_op_o           = op_q;
  assign mul_reg_waddr_o    = waddr_q;
  assign wb_waddr_o         = waddr_q;
  assign wb_wdata_o         = res_q;

endmodule

// File: tb/tb_ex_mul_ctrl.sv
// Directed bench for ex_mul_ctrl: table of multiply transactions plus
// hand sequences for flush, x0, back-pressure, watchdog and reset.
module tb_ex_mul_ctrl;

  localparam logic [2:0] INST_MUL    = 3'd0;
  localparam logic [2:0] INST_MULH   = 3'd1;
  localparam logic [2:0] INST_MULHSU = 3'd2;
  localparam logic [2:0] INST_MULHU  = 3'd3;

  logic        clk, rst;
  logic        ex_mul_req_i;
  logic [2:0]  ex_mul_op_i;
  logic [31:0] ex_rs1_i, ex_rs2_i;
  logic [4:0]  ex_waddr_i;
  logic        flush_i;
  logic        mul_start_o;
  logic [31:0] mul_multiplicand_o, mul_multiplier_o;
  logic [2:0]  mul_op_o;
  logic [4:0]  mul_reg_waddr_o;
  logic        mul_ready_i;
  logic [31:0] mul_res_i;
  logic        stall_o, wb_valid_o;
  logic [4:0]  wb_waddr_o;
  logic [31:0] wb_wdata_o;
  logic        wb_ready_i;
  logic        mul_err_o;

  int n_vec = 0;
  int n_err = 0;

  ex_mul_ctrl #(.TIMEOUT(63)) dut (
    .clk(clk), .rst(rst),
    .ex_mul_req_i(ex_mul_req_i), .ex_mul_op_i(ex_mul_op_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_waddr_i(ex_waddr_i),
    .flush_i(flush_i), .mul_start_o(mul_start_o),
    .mul_multiplicand_o(mul_multiplicand_o), .mul_multiplier_o(mul_multiplier_o),
    .mul_op_o(mul_op_o), .mul_reg_waddr_o(mul_reg_waddr_o),
    .mul_ready_i(mul_ready_i), .mul_res_i(mul_res_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_waddr_o(wb_waddr_o),
    .wb_wdata_o(wb_wdata_o), .wb_ready_i(wb_ready_i), .mul_err_o(mul_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  waddr;
    int          lat;
    int          wait_c;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    ex_mul_req_i = 1'b1;
    ex_mul_op_i  = op;
    ex_rs1_i     = a;
    ex_rs2_i     = b;
    ex_waddr_i   = wa;
  endtask

  task automatic drop_req;
    ex_mul_req_i = 1'b0;
    ex_mul_op_i  = 3'd7;
    ex_rs1_i     = 32'hDEADBEEF;
    ex_rs2_i     = 32'hCAFEF00D;
    ex_waddr_i   = 5'd0;
  endtask

  // full transaction: accept, lat RUN cycles with ready in the last, wait_c
  // back-pressured DONE cycles, handshake, then back in IDLE
  task automatic run_vec(input vec_t v);
    issue(v.op, v.rs1, v.rs2, v.waddr);
    settle;
    chk("accept_stall", stall_o, 1);
    chk("accept_start", mul_start_o, 0);
    tick;
    drop_req;
    for (int i = 1; i <= v.lat; i++) begin
      mul_ready_i = (i == v.lat);
      mul_res_i   = (i == v.lat) ? v.exp : 32'h5A5A5A5A;
      settle;
      chk("run_start", mul_start_o, 1);
      chk("run_stall", stall_o, 1);
      chk("run_rs1", mul_multiplicand_o, v.rs1);
      chk("run_rs2", mul_multiplier_o, v.rs2);
      chk("run_op", mul_op_o, v.op);
      chk("run_waddr", mul_reg_waddr_o, v.waddr);
      chk("run_valid", wb_valid_o, 0);
      tick;
    end
    mul_ready_i = 1'b0;
    mul_res_i   = 32'hA5A5A5A5;
    for (int w = 0; w < v.wait_c; w++) begin
      wb_ready_i = 1'b0;
      settle;
      chk("bp_valid", wb_valid_o, 1);
      chk("bp_data", wb_wdata_o, v.exp);
      chk("bp_waddr", wb_waddr_o, v.waddr);
      chk("bp_stall", stall_o, 1);
      chk("bp_start", mul_start_o, 0);
      tick;
    end
    wb_ready_i = 1'b1;
    settle;
    chk("wb_valid", wb_valid_o, 1);
    chk("wb_data", wb_wdata_o, v.exp);
    chk("wb_waddr", wb_waddr_o, v.waddr);
    chk("wb_stall", stall_o, 0);
    chk("wb_start", mul_start_o, 0);
    tick;
    wb_ready_i = 1'b0;
    settle;
    chk("post_valid", wb_valid_o, 0);
    chk("post_stall", stall_o, 0);
  endtask

  initial begin
    tbl[0] = '{INST_MUL,    32'd7,         32'd6,         5'd5,  4, 0, 32'd42};
    tbl[1] = '{INST_MULH,   32'hFFFFFFFD,  32'd5,         5'd10, 3, 0, 32'hFFFFFFFF};
    tbl[2] = '{INST_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  5'd17, 2, 0, 32'hFFFFFFFE};
    tbl[3] = '{INST_MULHSU, 32'hFFFFFFFF,  32'd2,         5'd1,  1, 0, 32'hFFFFFFFF};
    tbl[4] = '{INST_MUL,    32'd100,       32'd200,       5'd31, 2, 5, 32'd20000};

    rst = 1'b1;
    flush_i = 1'b0;
    mul_ready_i = 1'b0;
    mul_res_i = 32'h0;
    wb_ready_i = 1'b0;
    drop_req;
    #12;
    chk("rst_start", mul_start_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_valid", wb_valid_o, 0);
    chk("rst_wdata", wb_wdata_o, 0);
    chk("rst_waddr", wb_waddr_o, 0);
    chk("rst_rs1", mul_multiplicand_o, 0);
    chk("rst_err", mul_err_o, 0);
    tick;
    rst = 1'b0;
    tick;

    for (int k = 0; k < 5; k++) run_vec(tbl[k]);

    // flush 10 cycles into RUN, with a colliding ready: flush must win
    issue(INST_MUL, 32'd2, 32'd2, 5'd3);
    settle;
    tick;
    drop_req;
    for (int i = 1; i < 10; i++) begin
      settle;
      chk("fl_run_start", mul_start_o, 1);
      tick;
    end
    flush_i = 1'b1;
    mul_ready_i = 1'b1;
    mul_res_i = 32'd4;
    settle;
    chk("fl_start", mul_start_o, 0);
    chk("fl_stall", stall_o, 1);
    tick;
    flush_i = 1'b0;
    mul_ready_i = 1'b0;
    settle;
    chk("fl_idle_valid", wb_valid_o, 0);
    chk("fl_idle_stall", stall_o, 0);
    chk("fl_idle_start", mul_start_o, 0);
    begin
      vec_t v;
      v = '{INST_MUL, 32'd3, 32'd3, 5'd7, 2, 0, 32'd9};
      run_vec(v);
    end

    // x0 destination is a no-op
    issue(INST_MUL, 32'd1, 32'd1, 5'd0);
    settle;
    chk("x0_stall", stall_o, 0);
    chk("x0_start", mul_start_o, 0);
    tick;
    drop_req;
    settle;
    chk("x0_start_n", mul_start_o, 0);
    chk("x0_valid", wb_valid_o, 0);
    chk("x0_stall_n", stall_o, 0);

    // request together with flush in IDLE is not accepted
    issue(INST_MUL, 32'd1, 32'd1, 5'd6);
    flush_i = 1'b1;
    settle;
    chk("flreq_stall", stall_o, 0);
    tick;
    drop_req;
    flush_i = 1'b0;
    settle;
    chk("flreq_start", mul_start_o, 0);

    // stray ready in IDLE is ignored
    mul_ready_i = 1'b1;
    mul_res_i = 32'd123;
    settle;
    tick;
    mul_ready_i = 1'b0;
    settle;
    chk("stray_valid", wb_valid_o, 0);
    chk("stray_stall", stall_o, 0);

    // flush while DONE discards the result even with wb_ready high
    issue(INST_MUL, 32'd4, 32'd5, 5'd9);
    settle;
    tick;
    drop_req;
    mul_ready_i = 1'b1;
    mul_res_i = 32'd20;
    settle;
    tick;
    mul_ready_i = 1'b0;
    settle;
    chk("fd_valid", wb_valid_o, 1);
    chk("fd_data", wb_wdata_o, 32'd20);
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    settle;
    chk("fd_stall", stall_o, 1);
    tick;
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    settle;
    chk("fd_post_valid", wb_valid_o, 0);
    chk("fd_post_stall", stall_o, 0);

    // watchdog: 63 RUN cycles with start high, error pulse in the 64th
    issue(INST_MULHU, 32'd11, 32'd13, 5'd4);
    settle;
    tick;
    drop_req;
    for (int i = 0; i < 63; i++) begin
      settle;
      chk("wd_start", mul_start_o, 1);
      chk("wd_err_lo", mul_err_o, 0);
      tick;
    end
    settle;
    chk("wd_err", mul_err_o, 1);
    chk("wd_start_drop", mul_start_o, 0);
    tick;
    settle;
    chk("wd_err_once", mul_err_o, 0);
    chk("wd_stall", stall_o, 0);
    chk("wd_valid", wb_valid_o, 0);
    chk("wd_start_idle", mul_start_o, 0);

    // asynchronous reset mid-operation
    issue(INST_MUL, 32'd8, 32'd9, 5'd12);
    settle;
    tick;
    drop_req;
    settle;
    chk("ar_start_pre", mul_start_o, 1);
    rst = 1'b1;
    #1;
    chk("ar_start", mul_start_o, 0);
    chk("ar_stall", stall_o, 0);
    chk("ar_rs1", mul_multiplicand_o, 0);
    chk("ar_waddr", mul_reg_waddr_o, 0);
    tick;
    rst = 1'b0;
    settle;
    chk("ar_post_stall", stall_o, 0);
    chk("ar_post_valid", wb_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
